// File: rtl/tracker_defs.sv
// Shared definitions for the tracker voice and its pattern sequencer:
// sequencer FSM states, the rest-note marker and the note word field layout.
package tracker_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // A note word of all zeros means "rest": keep the pitch, silence the phase.
    localparam logic [15:0] REST_NOTE = 16'h0000;

    // Note word layout, low to high: tone, octave, instrument, volume, effect.
    localparam int TONE_LSB   = 0;
    localparam int TONE_W     = 4;
    localparam int OCTAVE_LSB = 4;
    localparam int OCTAVE_W   = 3;
    localparam int INSTR_LSB  = 7;
    localparam int INSTR_W    = 3;
    localparam int VOLUME_LSB = 10;
    localparam int VOLUME_W   = 3;
    localparam int EFFECT_LSB = 13;
    localparam int EFFECT_W   = 3;

    function automatic logic is_rest(input logic [15:0] n);
        return n == REST_NOTE;
    endfunction

endpackage

// File: rtl/pattern_ram.sv
// Generic single-write, single-read synchronous RAM. A read of the address
// being written in the same cycle returns the data stored before the write.
module pattern_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 20,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read registers the old contents while the write updates the array.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/tracker_sequencer.sv
// Pattern sequencer: steps through a row-indexed pattern RAM at a programmable
// tempo and presents each row's note/speed to the tracker voice.
module tracker_sequencer
    import tracker_defs::*;
#(
    parameter int ROWS     = 64,
    parameter int RLEN     = $clog2(ROWS),
    parameter int MAXSPEED = 16,
    parameter int SPLEN    = $clog2(MAXSPEED),
    parameter int TEMPO_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [RLEN-1:0]       wr_addr,
    input  logic [16+SPLEN-1:0]   wr_data,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop,
    input  logic [RLEN-1:0]       last_row,
    input  logic [TEMPO_W-1:0]    tempo,
    output logic [15:0]           note,
    output logic [SPLEN-1:0]      speed,
    output logic [RLEN-1:0]       row,
    output logic                  row_strobe,
    output logic                  busy,
    output logic                  done
);

    localparam int DW = 16 + SPLEN;

    seq_state_t          state;
    logic                loop_q;
    logic [RLEN-1:0]     last_q;
    logic [TEMPO_W-1:0]  tempo_q;
    logic [TEMPO_W-1:0]  count;
    logic [RLEN-1:0]     rd_addr;
    logic [DW-1:0]       rd_data;
    logic [RLEN-1:0]     row_next;
    logic [15:0]         rd_note;
    logic [SPLEN-1:0]    rd_speed;
    logic                hold_end;

    assign row_next = row + RLEN'(1);
    assign rd_note  = rd_data[DW-1:SPLEN];
    assign rd_speed = rd_data[SPLEN-1:0];
    assign hold_end = (count == TEMPO_W'(1));

    pattern_ram #(
        .DEPTH (ROWS),
        .WIDTH (DW),
        .AW    (RLEN)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Read address points at the row the next FETCH will present; in HOLD the
    // final cycle's read is the one FETCH consumes.
    always_comb begin
        rd_addr = row;
        case (state)
            ST_IDLE: rd_addr = '0;
            ST_HOLD: rd_addr = (row == last_q) ? '0 : row_next;
            default: rd_addr = row;
        endcase
    end

    // Sequencer FSM with registered outputs; stop overrides every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            loop_q     <= 1'b0;
            last_q     <= '0;
            tempo_q    <= '0;
            count      <= '0;
            note       <= '0;
            speed      <= '0;
            row        <= '0;
            row_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            row_strobe <= 1'b0;
            done       <= 1'b0;
            if (stop) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                speed <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            loop_q  <= loop;
                            last_q  <= last_row;
                            tempo_q <= (tempo == '0) ? TEMPO_W'(1) : tempo;
                            row     <= '0;
                            busy    <= 1'b1;
                            state   <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (is_rest(rd_note)) begin
                            speed <= '0;
                        end else begin
                            note  <= rd_note;
                            speed <= rd_speed;
                        end
                        row_strobe <= 1'b1;
                        count      <= tempo_q;
                        state      <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (hold_end) begin
                            if (row != last_q) begin
                                row   <= row_next;
                                state <= ST_FETCH;
                            end else if (loop_q) begin
                                row   <= '0;
                                state <= ST_FETCH;
                            end else begin
                                speed <= '0;
                                busy  <= 1'b0;
                                state <= ST_DONE;
                            end
                        end else begin
                            count <= count - TEMPO_W'(1);
                        end
                    end
                    ST_DONE: begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
